// File: rtl/noc_pkg.sv
// Shared constants and types for the 5-port mesh router.
package noc_pkg;

  localparam int N_PORTS = 5;
  localparam int PTR_W   = 3;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/output_port_rr_arbiter_rr_pick.sv
// Rotating-priority scan: first set bit of req at or above rr_ptr, wrapping modulo N_PORTS.
module rr_pick #(
  parameter int N_PORTS = 5,
  parameter int PTR_W   = 3
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               found,
  output logic [PTR_W-1:0]   idx
);

  int w_pos;

  // rr_ptr is always kept below N_PORTS, so a single subtraction wraps it.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_pos = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      w_pos = int'(rr_ptr) + k;
      if (w_pos >= N_PORTS) w_pos = w_pos - N_PORTS;
      if (!found && req[w_pos]) begin
        found = 1'b1;
        idx   = PTR_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/output_port_rr_arbiter.sv
// Per-output-port round-robin switch arbiter with wormhole grant locking.
// Handshake: a flit moves (xfer) in any cycle where grant_valid, req[owner] and out_ready are all high.
module output_port_rr_arbiter #(
  parameter int N_PORTS = noc_pkg::N_PORTS,
  parameter int PTR_W   = noc_pkg::PTR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_PORTS-1:0]  req,
  input  logic [N_PORTS-1:0]  tail,
  input  logic                out_ready,
  output logic [N_PORTS-1:0]  select,
  output logic                grant_valid,
  output logic [PTR_W-1:0]    owner,
  output logic                xfer,
  output logic                xfer_tail,
  output noc_pkg::arb_state_t o_dbg_state,
  output logic [PTR_W-1:0]    o_dbg_rr_ptr
);

  import noc_pkg::*;

  arb_state_t         r_state;
  logic [N_PORTS-1:0] r_select;
  logic               r_grant_valid;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_rr_ptr;

  logic               w_found;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_xfer;
  logic               w_xfer_tail;

  rr_pick #(
    .N_PORTS(N_PORTS),
    .PTR_W  (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .found  (w_found),
    .idx    (w_pick_idx)
  );

  assign w_xfer      = r_grant_valid & req[r_owner] & out_ready;
  assign w_xfer_tail = w_xfer & tail[r_owner];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ARB_IDLE;
      r_select      <= '0;
      r_grant_valid <= 1'b0;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_state       <= ARB_LOCKED;
            r_owner       <= w_pick_idx;
            r_select      <= N_PORTS'(1) << w_pick_idx;
            r_grant_valid <= 1'b1;
          end
        end
        ARB_LOCKED: begin
          // Pointer moves only when the packet finishes, so a grant alone never skips a port.
          if (w_xfer_tail) begin
            r_state       <= ARB_IDLE;
            r_select      <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= (r_owner == PTR_W'(N_PORTS - 1)) ? '0 : r_owner + 1'b1;
          end
        end
        default: begin
          r_state       <= ARB_IDLE;
          r_select      <= '0;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign select       = r_select;
  assign grant_valid  = r_grant_valid;
  assign owner        = r_owner;
  assign xfer         = w_xfer;
  assign xfer_tail    = w_xfer_tail;
  assign o_dbg_state  = r_state;
  assign o_dbg_rr_ptr = r_rr_ptr;

  a_select_consistent: assert property (@(posedge clk) disable iff (rst)
    $onehot0(r_select) && (r_grant_valid == |r_select));

endmodule
